// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master (CPU, DMA) arbiter in front of the memory/IO bus decoder.
// The CPU has priority. The DMA is forced onto the bus after MAX_WAIT consecutive
// denied request cycles. Each master can lock the bus for atomic multi-cycle sequences.
// Ports:
//   clk, clrn                   clock, asynchronous active-low reset
//   cpu_req/lock/a/wdata/wmem/rmem   CPU request side; cpu_stall, cpu_rdata back to CPU
//   dma_req/lock/a/wdata/wmem/rmem   DMA request side; dma_ack, dma_rdata back to DMA
//   mem_a, d_t_mem, wmem, rmem  bus master port to the decoder; d_f_mem is its read data
module mio_arbiter #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wmem,
  input  logic        cpu_rmem,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_wdata,
  input  logic        dma_wmem,
  input  logic        dma_rmem,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] d_t_mem,
  output logic        wmem,
  output logic        rmem,
  input  logic [31:0] d_f_mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DMA  = 2'b10
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state;
  state_t            state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;
  logic              hold;

  // wait_cnt is only cleared on the edge that leaves the first DMA cycle, so it still
  // reads MAX_WAIT during that cycle; starvation is therefore not raised while the DMA
  // already owns the bus, which limits a forced grant to exactly one cycle.
  assign starve = dma_req && (wait_cnt == WAIT_LIMIT) && (state != S_DMA);

  assign hold = ((state == S_CPU) && cpu_req && cpu_lock && !starve) ||
                ((state == S_DMA) && dma_req && dma_lock);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if (!dma_req || (state == S_DMA)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    if (hold) begin
      state_nx = state;
    end else if (starve) begin
      state_nx = S_DMA;
    end else if (cpu_req) begin
      state_nx = S_CPU;
    end else if (dma_req) begin
      state_nx = S_DMA;
    end
  end

  always_comb begin
    mem_a   = '0;
    d_t_mem = '0;
    wmem    = 1'b0;
    rmem    = 1'b0;
    case (state)
      S_CPU: begin
        mem_a   = cpu_a;
        d_t_mem = cpu_wdata;
        wmem    = cpu_req & cpu_wmem;
        rmem    = cpu_req & cpu_rmem;
      end
      S_DMA: begin
        mem_a   = dma_a;
        d_t_mem = dma_wdata;
        wmem    = dma_req & dma_wmem;
        rmem    = dma_req & dma_rmem;
      end
      default: begin
      end
    endcase
  end

  assign cpu_stall = cpu_req & (state != S_CPU);
  assign dma_ack   = dma_req & (state == S_DMA);
  assign cpu_rdata = d_f_mem;
  assign dma_rdata = d_f_mem;

endmodule

// File: tb/tb_mio_arbiter.sv
module tb_mio_arbiter;

  localparam logic [31:0] CA = 32'h0000_0800;
  localparam logic [31:0] CD = 32'h1111_1111;
  localparam logic [31:0] DA = 32'hC000_0000;
  localparam logic [31:0] DD = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_req, cpu_lock, cpu_wmem, cpu_rmem;
  logic [31:0] cpu_a, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_lock, dma_wmem, dma_rmem;
  logic [31:0] dma_a, dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] mem_a, d_t_mem;
  logic        wmem, rmem;
  logic [31:0] d_f_mem;

  mio_arbiter #(.MAX_WAIT(16), .WAIT_W(5)) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
    .cpu_wmem(cpu_wmem), .cpu_rmem(cpu_rmem), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_a(dma_a), .dma_wdata(dma_wdata),
    .dma_wmem(dma_wmem), .dma_rmem(dma_rmem), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_a(mem_a), .d_t_mem(d_t_mem), .wmem(wmem), .rmem(rmem), .d_f_mem(d_f_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        rn;
    logic        creq, cl, cw, cr;
    logic [31:0] ca;
    logic        dreq, dl, dw, dr;
    logic [31:0] da, dd, fm;
    logic        e_stall, e_ack, e_w, e_r;
    logic [31:0] e_a, e_d;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rn, input logic creq, input logic cl, input logic cw, input logic cr,
    input logic [31:0] ca, input logic dreq, input logic dl, input logic dw, input logic dr,
    input logic [31:0] da, input logic [31:0] dd,
    input logic es, input logic ea, input logic ew, input logic er,
    input logic [31:0] xa, input logic [31:0] xd);
    vec_t v;
    v.id = 0; v.rn = rn;
    v.creq = creq; v.cl = cl; v.cw = cw; v.cr = cr; v.ca = ca;
    v.dreq = dreq; v.dl = dl; v.dw = dw; v.dr = dr; v.da = da; v.dd = dd;
    v.fm = 32'h0;
    v.e_stall = es; v.e_ack = ea; v.e_w = ew; v.e_r = er; v.e_a = xa; v.e_d = xd;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vec_t t;
    t    = v;
    t.id = vecs.size();
    t.fm = 32'h5A00_0000 + 32'(vecs.size() * 7);
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t v);
    clrn = v.rn;
    cpu_req = v.creq; cpu_lock = v.cl; cpu_wmem = v.cw; cpu_rmem = v.cr;
    cpu_a = v.ca; cpu_wdata = CD;
    dma_req = v.dreq; dma_lock = v.dl; dma_wmem = v.dw; dma_rmem = v.dr;
    dma_a = v.da; dma_wdata = v.dd;
    d_f_mem = v.fm;
  endtask

  // Scoreboard: every driven vector is checked at the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t v;
      v = exp_q.pop_front();
      chk($sformatf("v%0d.cpu_stall", v.id), 32'(cpu_stall), 32'(v.e_stall));
      chk($sformatf("v%0d.dma_ack", v.id), 32'(dma_ack), 32'(v.e_ack));
      chk($sformatf("v%0d.wmem", v.id), 32'(wmem), 32'(v.e_w));
      chk($sformatf("v%0d.rmem", v.id), 32'(rmem), 32'(v.e_r));
      chk($sformatf("v%0d.mem_a", v.id), mem_a, v.e_a);
      chk($sformatf("v%0d.d_t_mem", v.id), d_t_mem, v.e_d);
      chk($sformatf("v%0d.cpu_rdata", v.id), cpu_rdata, v.fm);
      chk($sformatf("v%0d.dma_rdata", v.id), dma_rdata, v.fm);
    end
  end

  initial begin
    apply(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0));

    // Reset hold, release, first CPU read, owner drop.
    add(mk(0, 1,0,0,1,CA, 0,0,0,0,0,0,   1,0,0,0,0,0));
    add(mk(0, 1,0,0,1,CA, 1,0,1,0,DA,DD, 1,0,0,0,0,0));
    add(mk(1, 1,0,0,1,CA, 0,0,0,0,0,0,   1,0,0,0,0,0));
    add(mk(1, 1,0,0,1,CA, 0,0,0,0,0,0,   0,0,0,1,CA,CD));
    add(mk(1, 0,0,0,1,CA, 0,0,0,0,0,0,   0,0,0,0,CA,CD));
    add(mk(1, 0,0,0,0,0,  0,0,0,0,0,0,   0,0,0,0,0,0));
    // DMA alone: grant next cycle, then drop while granted.
    add(mk(1, 0,0,0,0,0,  1,0,1,0,DA,DD, 0,0,0,0,0,0));
    add(mk(1, 0,0,0,0,0,  1,0,1,0,DA,DD, 0,1,1,0,DA,DD));
    add(mk(1, 0,0,0,0,0,  0,0,1,0,DA,DD, 0,0,0,0,DA,DD));
    add(mk(1, 0,0,0,0,0,  0,0,0,0,0,0,   0,0,0,0,0,0));
    // Starvation with CPU unlocked, then locked: 16 CPU cycles, one DMA cycle, repeat.
    for (int lk = 0; lk < 2; lk++) begin
      for (int k = 0; k <= 36; k++) begin
        if (k == 0)
          add(mk(1, 1,1'(lk),0,1,CA, 1,0,1,0,DA,DD, 1,0,0,0,0,0));
        else if (k == 17 || k == 35)
          add(mk(1, 1,1'(lk),0,1,CA, 1,0,1,0,DA,DD, 1,1,1,0,DA,DD));
        else
          add(mk(1, 1,1'(lk),0,1,CA, 1,0,1,0,DA,DD, 0,0,0,1,CA,CD));
      end
      add(mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,CD));
      add(mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0));
    end
    // Locked DMA burst of 4 writes while the CPU waits.
    add(mk(1, 0,0,0,0,0, 1,1,1,0,DA,DD, 0,0,0,0,0,0));
    for (int j = 1; j <= 4; j++) begin
      add(mk(1, 1,0,1,0,CA, 1,1'(j < 4),1,0,DA + 32'(4*(j-1)),DD + 32'(j),
             1,1,1,0,DA + 32'(4*(j-1)),DD + 32'(j)));
    end
    add(mk(1, 1,0,1,0,CA, 0,0,0,0,0,0, 0,0,1,0,CA,CD));
    add(mk(1, 0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0,0,CD));
    add(mk(1, 0,0,0,0,0,  0,0,0,0,0,0, 0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      exp_q.push_back(vecs[i]);
    end
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // Asynchronous reset in the middle of a DMA write cycle.
    @(posedge clk); #1;
    apply(mk(1, 0,0,0,0,0, 1,0,1,0,DA,DD, 0,0,0,0,0,0));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rmem = 1'b1; cpu_a = CA;
    #2;
    chk("rst.pre_wmem", 32'(wmem), 32'd1);
    chk("rst.pre_ack", 32'(dma_ack), 32'd1);
    #1 clrn = 1'b0;
    #1;
    chk("rst.wmem", 32'(wmem), 32'd0);
    chk("rst.rmem", 32'(rmem), 32'd0);
    chk("rst.ack", 32'(dma_ack), 32'd0);
    chk("rst.stall", 32'(cpu_stall), 32'd1);
    chk("rst.mem_a", mem_a, 32'h0);
    @(posedge clk); #1;
    clrn = 1'b1;
    @(negedge clk);
    chk("rel.c0_stall", 32'(cpu_stall), 32'd1);
    chk("rel.c0_ack", 32'(dma_ack), 32'd0);
    @(negedge clk);
    chk("rel.c1_stall", 32'(cpu_stall), 32'd0);
    chk("rel.c1_rmem", 32'(rmem), 32'd1);
    chk("rel.c1_mem_a", mem_a, CA);
    chk("rel.c1_ack", 32'(dma_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
